// File: rtl/mem_write_pkg.sv
// Shared memory-write types and helpers, reused by the ALU write port,
// the memory controller and the write arbiter.
package mem_write_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int DATA_WIDTH     = 32;
  localparam int NUM_LANES      = 4;
  localparam int LANE_IDX_W     = $clog2(NUM_LANES);

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } mem_write_s;

  // Increment a lane index, wrapping at n (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered empty/full flags; a push and a pop in
// the same cycle are both performed.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CNT_W'(depth));
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide what is
  // valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_write_arb.sv
// Arbitrates per-lane memory writes onto one registered valid/ready channel.
// Define MEM_WRITE_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module mem_write_arb
  import mem_write_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int mem_addr_width = 16,
  parameter int data_width     = 32,
  parameter int depth          = 2
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [NUM_REQ-1:0]                       w_valid_i,
  input  logic [NUM_REQ-1:0][mem_addr_width-1:0]   w_addr_i,
  input  logic [NUM_REQ-1:0][data_width-1:0]       w_write_i,
  output logic [NUM_REQ-1:0]                       full_o,
  output logic [NUM_REQ-1:0]                       overflow_o,
  output logic                                     mem_valid_o,
  output logic [mem_addr_width-1:0]                mem_addr_o,
  output logic [data_width-1:0]                    mem_data_o,
  output logic [$clog2(NUM_REQ)-1:0]               mem_src_o,
  input  logic                                     mem_ready_i
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int ENT_W = mem_addr_width + data_width;

  logic [NUM_REQ-1:0]            empty, pop;
  logic [NUM_REQ-1:0][ENT_W-1:0] head;
  logic                          can_load;
  logic                          gnt_valid;
  logic [SRC_W-1:0]              gnt_idx;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    sync_fifo #(
      .width (ENT_W),
      .depth (depth)
    ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push    (w_valid_i[k]),
      .pop     (pop[k]),
      .din     ({w_addr_i[k], w_write_i[k]}),
      .dout    (head[k]),
      .empty   (empty[k]),
      .full    (full_o[k])
    );
  end

  // The output register takes a new entry when empty or being accepted.
  assign can_load = !mem_valid_o || mem_ready_i;

`ifdef MEM_WRITE_ARB_FIXED_PRIO_EN
  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_W'(i);
      end
    end
  end
`else
  logic [SRC_W-1:0] rr;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr) + off) % NUM_REQ;
      if (!gnt_valid && !empty[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr <= '0;
    end else if (can_load && gnt_valid) begin
      rr <= SRC_W'(wrap_inc(int'(gnt_idx), NUM_REQ));
    end
  end
`endif

  always_comb begin
    pop = '0;
    if (can_load && gnt_valid) pop[gnt_idx] = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_src_o   <= '0;
    end else if (can_load) begin
      mem_valid_o <= gnt_valid;
      if (gnt_valid) begin
        {mem_addr_o, mem_data_o} <= head[gnt_idx];
        mem_src_o                <= gnt_idx;
      end
    end
  end

  // Sticky until reset: a request landed on a full lane and was dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) overflow_o <= '0;
    else         overflow_o <= overflow_o | (w_valid_i & full_o);
  end

endmodule

// File: tb/tb_mem_write_arb.sv
// Directed self-checking bench for mem_write_arb (default round-robin build).
module tb_mem_write_arb;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic [N-1:0]          w_valid_i;
  logic [N-1:0][AW-1:0]  w_addr_i;
  logic [N-1:0][DW-1:0]  w_write_i;
  logic [N-1:0]          full_o, overflow_o;
  logic                  mem_valid_o;
  logic [AW-1:0]         mem_addr_o;
  logic [DW-1:0]         mem_data_o;
  logic [1:0]            mem_src_o;
  logic                  mem_ready_i;

  int vectors     = 0;
  int miscompares = 0;

  mem_write_arb #(
    .NUM_REQ(N), .mem_addr_width(AW), .data_width(DW), .depth(2)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .w_valid_i   (w_valid_i),
    .w_addr_i    (w_addr_i),
    .w_write_i   (w_write_i),
    .full_o      (full_o),
    .overflow_o  (overflow_o),
    .mem_valid_o (mem_valid_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_src_o   (mem_src_o),
    .mem_ready_i (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},    64'(mem_valid_o), 64'd0);
    check({tag, "_addr"},     64'(mem_addr_o),  64'd0);
    check({tag, "_data"},     64'(mem_data_o),  64'd0);
    check({tag, "_src"},      64'(mem_src_o),   64'd0);
    check({tag, "_full"},     64'(full_o),      64'd0);
    check({tag, "_overflow"}, 64'(overflow_o),  64'd0);
  endtask

  initial begin
    reset_i     = 1'b1;
    w_valid_i   = '0;
    w_addr_i    = '0;
    w_write_i   = '0;
    mem_ready_i = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    reset_i = 1'b0;

    // Single write on lane 2: valid two edges after the request.
    mem_ready_i  = 1'b1;
    w_valid_i[2] = 1'b1;
    w_addr_i[2]  = 16'h0010;
    w_write_i[2] = 32'hDEADBEEF;
    tick();
    w_valid_i = '0;
    check("single_lat_valid", 64'(mem_valid_o), 64'd0);
    tick();
    check("single_valid", 64'(mem_valid_o), 64'd1);
    check("single_addr",  64'(mem_addr_o),  64'h0010);
    check("single_data",  64'(mem_data_o),  64'hDEADBEEF);
    check("single_src",   64'(mem_src_o),   64'd2);
    tick();
    check("single_drop_valid", 64'(mem_valid_o), 64'd0);

    // Round-robin fairness: reset rr, then two batches of four simultaneous writes.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < N; k++) begin
        w_addr_i[k]  = AW'(16'h0100 + k);
        w_write_i[k] = DW'(32'hA0 + 16 * b + k);
      end
      w_valid_i = '1;
      tick();
      w_valid_i = '0;
      for (int k = 0; k < N; k++) begin
        tick();
        check($sformatf("rr_b%0d_valid%0d", b, k), 64'(mem_valid_o), 64'd1);
        check($sformatf("rr_b%0d_src%0d",   b, k), 64'(mem_src_o),   64'(k));
        check($sformatf("rr_b%0d_data%0d",  b, k), 64'(mem_data_o),  64'(32'hA0 + 16 * b + k));
      end
      tick();
      check($sformatf("rr_b%0d_idle", b), 64'(mem_valid_o), 64'd0);
    end

    // Backpressure: output held stable for 5 cycles, accepted once ready rises.
    mem_ready_i  = 1'b0;
    w_valid_i[0] = 1'b1;
    w_addr_i[0]  = 16'h0001;
    w_write_i[0] = 32'h11;
    tick();
    w_valid_i = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid%0d", c), 64'(mem_valid_o), 64'd1);
      check($sformatf("bp_addr%0d",  c), 64'(mem_addr_o),  64'h0001);
      check($sformatf("bp_data%0d",  c), 64'(mem_data_o),  64'h11);
      tick();
    end
    mem_ready_i = 1'b1;
    tick();
    check("bp_accepted_once", 64'(mem_valid_o), 64'd0);

    // Full and overflow on lane 1 with ready low: 3 held, 4th dropped.
    mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_valid_i[1] = 1'b1;
      w_addr_i[1]  = AW'(16'h0020 + i);
      w_write_i[1] = DW'(32'hC1 + i);
      tick();
      if (i < 2) check($sformatf("full_after%0d", i + 1), 64'(full_o[1]), 64'd0);
      else       check($sformatf("full_after%0d", i + 1), 64'(full_o[1]), 64'd1);
      if (i < 3) check($sformatf("ovf_after%0d", i + 1), 64'(overflow_o[1]), 64'd0);
      else       check("ovf_after4", 64'(overflow_o[1]), 64'd1);
    end
    w_valid_i = '0;
    check("ovf_head_data", 64'(mem_data_o), 64'hC1);
    mem_ready_i = 1'b1;
    tick();
    check("ovf_out2_data", 64'(mem_data_o), 64'hC2);
    check("ovf_out2_addr", 64'(mem_addr_o), 64'h0021);
    check("ovf_full_clear", 64'(full_o[1]), 64'd0);
    tick();
    check("ovf_out3_data", 64'(mem_data_o), 64'hC3);
    check("ovf_out3_valid", 64'(mem_valid_o), 64'd1);
    tick();
    check("ovf_no_4th", 64'(mem_valid_o), 64'd0);
    check("ovf_sticky", 64'(overflow_o[1]), 64'd1);

    // Simultaneous push/pop on lane 3 for 10 cycles with ready high.
    for (int i = 0; i < 10; i++) begin
      w_valid_i[3] = 1'b1;
      w_addr_i[3]  = AW'(16'h0300 + i);
      w_write_i[3] = DW'(32'h300 + i);
      tick();
      check($sformatf("pp_full%0d", i), 64'(full_o[3]), 64'd0);
      if (i >= 1) begin
        check($sformatf("pp_valid%0d", i), 64'(mem_valid_o), 64'd1);
        check($sformatf("pp_data%0d",  i), 64'(mem_data_o),  64'(32'h300 + i - 1));
        check($sformatf("pp_src%0d",   i), 64'(mem_src_o),   64'd3);
      end
    end
    w_valid_i = '0;
    tick();
    check("pp_last_data",  64'(mem_data_o),  64'h309);
    check("pp_last_valid", 64'(mem_valid_o), 64'd1);
    tick();
    check("pp_idle", 64'(mem_valid_o), 64'd0);
    check("pp_no_overflow", 64'(overflow_o[3]), 64'd0);

    // Reset mid-operation: fill lanes 0-1, reset, expect nothing stale.
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_valid_i    = 4'b0011;
      w_write_i[0] = DW'(32'hE0 + i);
      w_write_i[1] = DW'(32'hF0 + i);
      tick();
    end
    w_valid_i = '0;
    check("mid_filled_valid", 64'(mem_valid_o), 64'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_reset_state("mid_reset");
    mem_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mid_no_stale%0d", c), 64'(mem_valid_o), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_write_arb.md
# mem_write_arb

Arbitrates the memory write ports of `NUM_REQ` ALU lanes onto one shared memory write channel. Each lane's `w_valid_o`/`w_addr_o`/`w_write_o` triple is captured into a per-lane FIFO. A round-robin arbiter drains those FIFOs into a single registered output with a valid/ready handshake. Per-lane full flags are fed back to the control unit so it can stall lanes before writes are lost.

## Interface

Parameters:
- `NUM_REQ`, 4: number of ALU lanes (≥2).
- `mem_addr_width`, 16: memory address width, matching the ALU.
- `data_width`, 32: write data width (`REG_WIDTH`).
- `depth`, 2: entries per lane FIFO (power of two, ≥2).

Ports:
- `clk_i`  in  1: clock. One clock domain.
- `reset_i`  in  1: synchronous, active-high reset.
- `w_valid_i`  in  `NUM_REQ`: per-lane write request, one write per cycle while high.
- `w_addr_i`  in  `NUM_REQ`×`mem_addr_width`: per-lane write address.
- `w_write_i`  in  `NUM_REQ`×`data_width`: per-lane write data.
- `full_o`  out  `NUM_REQ`: lane FIFO full; the control unit stalls that lane.
- `overflow_o`  out  `NUM_REQ`: sticky flag, set when a request arrived while the lane FIFO was full.
- `mem_valid_o`  out  1: output write is valid.
- `mem_addr_o`  out  `mem_addr_width`: output address.
- `mem_data_o`  out  `data_width`: output data.
- `mem_src_o`  out  `$clog2(NUM_REQ)`: lane that issued the output write.
- `mem_ready_i`  in  1: memory accepts the write.

## Operation

- **Enqueue.**
  - A request on lane k is pushed on the edge where `w_valid_i[k] && !full_o[k]`.
  - If `w_valid_i[k] && full_o[k]`, the request is dropped and `overflow_o[k]` is set. It stays set until reset.
  - A push and a pop on the same lane in the same cycle are both performed. The count is unchanged and `full_o` does not deassert-then-reassert.
- **Output register** holds one entry: `{addr, data, src}` plus `mem_valid_o`.
  - It may load when empty (`!mem_valid_o`) or when being accepted (`mem_valid_o && mem_ready_i`).
  - When it can load and at least one FIFO is non-empty, the arbiter picks lane g. The head of g loads into the output register, g is popped, and `mem_valid_o` becomes 1.
  - When it can load and all FIFOs are empty, `mem_valid_o` becomes 0.
  - While `mem_valid_o && !mem_ready_i`, `mem_addr_o`, `mem_data_o` and `mem_src_o` are held stable.
- **Round-robin.**
  - Pointer `rr` is reset to 0.
  - The search order is `rr, rr+1, …, rr+NUM_REQ-1` modulo `NUM_REQ`.
  - After a grant to lane g, `rr` becomes `(g+1) mod NUM_REQ`. It wraps from `NUM_REQ-1` to 0.
  - `rr` is unchanged in cycles with no grant.
- **Ordering.** Writes from one lane leave in issue order. Writes from different lanes have no ordering guarantee.
- **Reset mid-operation.** All FIFOs are emptied, the output register is cleared, and any pending writes are discarded.

## Timing

- Reset values: `mem_valid_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `mem_src_o`=0, `full_o`=0, `overflow_o`=0, `rr`=0.
- Latency: a request sampled at edge t (lane idle, output empty) appears on `mem_valid_o` after edge t+1, i.e. 2 cycles request-to-valid.
- Throughput: one write per cycle when `mem_ready_i` is held high.
- `full_o[k]` is registered. It asserts the cycle after the push that fills the FIFO.
- `mem_ready_i` may be high while `mem_valid_o`=0; this has no effect.

## Configuration

- `MEM_WRITE_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority is used instead of round-robin. The lowest-index non-empty lane always wins and `rr` is not implemented.
  - Undefined (default): round-robin as described above.
  - All other behaviour is identical in both modes.

## Structure

- Shared package `mem_write_pkg`:
  - `mem_write_s` packed struct `{addr, data}`.
  - Lane index width constant.
  - Reused by the ALU write port and the memory controller.
- Sub-module `sync_fifo`:
  - One per lane, instantiated in a generate loop.
  - Parameters: width, depth.
  - Ports: push, pop, data in/out, empty, full.
  - Registered outputs, same-cycle push/pop allowed.
- Arbiter and output register live in `mem_write_arb`.

## Test plan

- **Single write.** Lane 2 writes addr 0x0010, data 0xDEADBEEF for one cycle, `mem_ready_i`=1. Expect `mem_valid_o`=1 two cycles later with addr 0x0010, data 0xDEADBEEF, `mem_src_o`=2, then 0.
- **Round-robin fairness.** All 4 lanes issue one write in the same cycle, ready high. Expect the output order to be lanes 0,1,2,3 on consecutive cycles. A second batch issued after `rr` has wrapped to 0 follows the same order.
- **Backpressure hold.** Lane 0 writes 0x0001/0x11, `mem_ready_i`=0 for 5 cycles. Expect `mem_valid_o`, addr and data stable for all 5 cycles, and accepted once on the cycle ready rises.
- **Full and overflow.** With `depth`=2 and ready low, lane 1 issues 4 consecutive writes. Expect `full_o[1]`=1 after the 3rd write (2 in the FIFO plus 1 in the output register would mean only 3 held). Expect the 4th write dropped and `overflow_o[1]`=1. Then raise ready and expect exactly the first 3 writes, in order.
- **Simultaneous push/pop.** Lane 3 writes every cycle for 10 cycles, ready high. Expect `full_o[3]` never set, 10 outputs with incrementing data, and no overflow.
- **Reset mid-operation.** Fill lanes 0–1 with ready low, then assert `reset_i` for 1 cycle. Expect all outputs at reset values and no stale writes emitted afterwards.
